// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-latency arbiter sharing one single-port memory between fetch and data ports
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state, state_nxt;
    logic last_grant;
    logic owner;
    logic grant_d;
    logic [3:0] cnt;
    assign grant_d = d_req && (!i_req || !last_grant);
    assign busy = state != IDLE;
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end
    // next-state: grant in IDLE, one issue cycle, count down latency, one done cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (i_req || d_req) ? ISSUE : IDLE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = (cnt == 4'd1) ? DONE : WAIT;
            default: state_nxt = IDLE;
        endcase
    end
    // datapath: latch the granted command, strobe memory, capture read data, pulse done
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            last_grant <= 1'b0;
            owner      <= 1'b0;
            cnt        <= 4'd0;
        end else begin
            mem_en <= 1'b0;
            i_done <= 1'b0;
            d_done <= 1'b0;
            if (state == IDLE && (i_req || d_req)) begin
                owner      <= grant_d;
                last_grant <= grant_d;
                mem_en     <= 1'b1;
                mem_wr     <= grant_d && d_wr;
                mem_addr   <= grant_d ? d_addr : i_addr;
                mem_wdata  <= grant_d ? d_wdata : mem_wdata;
            end
            if (state == ISSUE) cnt <= 4'(MEM_LAT);
            if (state == WAIT) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    if (!mem_wr && owner) d_rdata <= mem_rdata;
                    if (!mem_wr && !owner) i_rdata <= mem_rdata;
                    d_done <= owner;
                    i_done <= !owner;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter at MEM_LAT 4, 1 and 15
module tb_mem_arbiter;
    typedef struct {int inst; bit is_d; int cyc; logic [15:0] iv; logic [15:0] dv;} done_t;
    typedef struct {int inst; bit wr; logic [15:0] addr; logic [15:0] wdata; int cyc;} cmd_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] i_req, d_req, d_wr, i_done, d_done, mem_en, mem_wr, busy;
    logic [2:0][15:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    done_t dq[$];
    cmd_t cq[$];
    done_t de;
    cmd_t ce;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [15:0] dflt(logic [15:0] a);
        return a == 16'h0010 ? 16'hB123 : a ^ 16'h5A5A;
    endfunction
    for (genvar g = 0; g < 3; g++) begin : u
        localparam int L = g == 0 ? 4 : (g == 1 ? 1 : 15);
        logic [15:0] mem [256];
        bit wv [256];
        logic [4:0] pend = 5'd0;
        logic [15:0] pdata = 16'h0;
        mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(L)) dut (
            .clk(clk), .rst(rst),
            .i_req(i_req[g]), .i_addr(i_addr[g]), .i_done(i_done[g]), .i_rdata(i_rdata[g]),
            .d_req(d_req[g]), .d_wr(d_wr[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
            .d_done(d_done[g]), .d_rdata(d_rdata[g]),
            .mem_en(mem_en[g]), .mem_wr(mem_wr[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
        );
        // memory model: writes on mem_en, read data valid exactly L cycles after mem_en
        always @(posedge clk) begin
            if (mem_en[g] && mem_wr[g]) begin
                mem[mem_addr[g][7:0]] <= mem_wdata[g];
                wv[mem_addr[g][7:0]] <= 1'b1;
            end
            if (mem_en[g] && !mem_wr[g]) begin
                pend <= 5'(L);
                pdata <= wv[mem_addr[g][7:0]] ? mem[mem_addr[g][7:0]] : dflt(mem_addr[g]);
            end else if (pend != 5'd0) pend <= pend - 5'd1;
        end
        assign mem_rdata[g] = (pend == 5'd1) ? pdata : 16'hDEAD;
    end
    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, a, e, cyc);
        end
    endtask
    // monitor: compare every memory command and every done pulse against the queues
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mem_en[k]) begin
                if (cq.size() == 0) chk("unexpected mem_en", 32'(k), 32'hFFFF_FFFF);
                else begin
                    ce = cq.pop_front();
                    chk("cmd.inst", 32'(k), 32'(ce.inst));
                    chk("cmd.cyc", 32'(cyc), 32'(ce.cyc));
                    chk("cmd.wr", 32'(mem_wr[k]), 32'(ce.wr));
                    chk("cmd.addr", 32'(mem_addr[k]), 32'(ce.addr));
                    if (ce.wr) chk("cmd.wdata", 32'(mem_wdata[k]), 32'(ce.wdata));
                end
            end
            for (int j = 0; j < 2; j++) begin
                if (j == 0 ? i_done[k] : d_done[k]) begin
                    if (dq.size() == 0) chk("unexpected done", 32'(k * 2 + j), 32'hFFFF_FFFF);
                    else begin
                        de = dq.pop_front();
                        chk("done.inst", 32'(k), 32'(de.inst));
                        chk("done.kind", 32'(j), 32'(de.is_d));
                        chk("done.cyc", 32'(cyc), 32'(de.cyc));
                        chk("i_rdata", 32'(i_rdata[k]), 32'(de.iv));
                        chk("d_rdata", 32'(d_rdata[k]), 32'(de.dv));
                    end
                end
            end
        end
    end
    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic exp_cmd(int k, bit wr, logic [15:0] a, logic [15:0] w, int c);
        cq.push_back('{inst: k, wr: wr, addr: a, wdata: w, cyc: c});
    endtask
    task automatic exp_done(int k, bit is_d, int c, logic [15:0] iv, logic [15:0] dv);
        dq.push_back('{inst: k, is_d: is_d, cyc: c, iv: iv, dv: dv});
    endtask
    task automatic chk_zero(int k);
        chk("rst.mem_en", 32'(mem_en[k]), 0);
        chk("rst.mem_wr", 32'(mem_wr[k]), 0);
        chk("rst.mem_addr", 32'(mem_addr[k]), 0);
        chk("rst.mem_wdata", 32'(mem_wdata[k]), 0);
        chk("rst.i_done", 32'(i_done[k]), 0);
        chk("rst.d_done", 32'(d_done[k]), 0);
        chk("rst.i_rdata", 32'(i_rdata[k]), 0);
        chk("rst.d_rdata", 32'(d_rdata[k]), 0);
        chk("rst.busy", 32'(busy[k]), 0);
    endtask
    // one isolated access sampled in the current IDLE cycle; requester drops on its done cycle
    task automatic run_one(int k, bit is_d, bit wr, logic [15:0] a, logic [15:0] w, int lat,
                           logic [15:0] iv, logic [15:0] dv);
        int c0 = cyc;
        if (is_d) begin
            d_req[k] = 1'b1; d_wr[k] = wr; d_addr[k] = a; d_wdata[k] = w;
        end else begin
            i_req[k] = 1'b1; i_addr[k] = a;
        end
        exp_cmd(k, is_d && wr, a, w, c0 + 1);
        exp_done(k, is_d, c0 + lat + 2, iv, dv);
        tick(1);
        chk("busy.start", 32'(busy[k]), 1);
        tick(lat + 1);
        chk("busy.done", 32'(busy[k]), 1);
        i_req[k] = 1'b0;
        d_req[k] = 1'b0;
        tick(1);
        chk("busy.idle", 32'(busy[k]), 0);
    endtask
    initial begin
        int c0;
        i_req = '0; d_req = '0; d_wr = '0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        tick(2);
        for (int k = 0; k < 3; k++) chk_zero(k);
        rst = 1'b0;
        tick(1);
        // fetch, store, load at MEM_LAT 4
        run_one(0, 1'b0, 1'b0, 16'h0010, 16'h0000, 4, 16'hB123, 16'h0000);
        run_one(0, 1'b1, 1'b1, 16'h0040, 16'h00AA, 4, 16'hB123, 16'h0000);
        run_one(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 4, 16'hB123, 16'h00AA);
        // contention from reset: D, I, D, I spaced 7 cycles apart
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        c0 = cyc;
        i_req[0] = 1'b1; i_addr[0] = 16'h0030;
        d_req[0] = 1'b1; d_wr[0] = 1'b0; d_addr[0] = 16'h0020;
        exp_cmd(0, 1'b0, 16'h0020, 16'h0, c0 + 1);
        exp_done(0, 1'b1, c0 + 6, 16'h0000, 16'h5A7A);
        exp_cmd(0, 1'b0, 16'h0030, 16'h0, c0 + 8);
        exp_done(0, 1'b0, c0 + 13, 16'h5A6A, 16'h5A7A);
        exp_cmd(0, 1'b0, 16'h0020, 16'h0, c0 + 15);
        exp_done(0, 1'b1, c0 + 20, 16'h5A6A, 16'h5A7A);
        exp_cmd(0, 1'b0, 16'h0030, 16'h0, c0 + 22);
        exp_done(0, 1'b0, c0 + 27, 16'h5A6A, 16'h5A7A);
        tick(27);
        i_req[0] = 1'b0;
        d_req[0] = 1'b0;
        tick(1);
        // reset during WAIT of a load, request held through reset is never granted
        c0 = cyc;
        d_req[0] = 1'b1; d_wr[0] = 1'b0; d_addr[0] = 16'h0040;
        exp_cmd(0, 1'b0, 16'h0040, 16'h0, c0 + 1);
        tick(3);
        rst = 1'b1;
        tick(1);
        chk_zero(0);
        tick(1);
        d_req[0] = 1'b0;
        rst = 1'b0;
        tick(2);
        run_one(0, 1'b0, 1'b0, 16'h0010, 16'h0000, 4, 16'hB123, 16'h0000);
        // fetch dropped right after its grant; short pulse during the access is ignored
        c0 = cyc;
        i_req[0] = 1'b1; i_addr[0] = 16'h0030;
        exp_cmd(0, 1'b0, 16'h0030, 16'h0, c0 + 1);
        exp_done(0, 1'b0, c0 + 6, 16'h5A6A, 16'h0000);
        tick(1);
        i_req[0] = 1'b0;
        tick(1);
        i_req[0] = 1'b1;
        tick(3);
        i_req[0] = 1'b0;
        tick(3);
        chk("drop.busy", 32'(busy[0]), 0);
        // latency sweep
        run_one(1, 1'b0, 1'b0, 16'h0010, 16'h0000, 1, 16'hB123, 16'h0000);
        run_one(1, 1'b1, 1'b0, 16'h0020, 16'h0000, 1, 16'hB123, 16'h5A7A);
        run_one(2, 1'b0, 1'b0, 16'h0030, 16'h0000, 15, 16'h5A6A, 16'h0000);
        run_one(2, 1'b1, 1'b1, 16'h0050, 16'h1234, 15, 16'h5A6A, 16'h0000);
        run_one(2, 1'b1, 1'b0, 16'h0050, 16'h0000, 15, 16'h5A6A, 16'h1234);
        for (int t = 0; t < 50 && (dq.size() != 0 || cq.size() != 0); t++) tick(1);
        chk("drain.pending", 32'(dq.size() + cq.size()), 0);
        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Fixed-latency arbiter that shares one unified single-port memory between the CPU's instruction-fetch port and data-access port. It sits between the fetch/PC logic and load/store path on one side and the memory model on the other. It grants one access at a time, alternates priority under contention, and tracks memory latency with a counter. It returns read data with a one-cycle done pulse per requester.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 4, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  instruction fetch request; held high until i_done
- i_addr  in  ADDR_W  fetch address
- i_done  out  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  out  DATA_W  fetched word; holds until next fetch completes
- d_req  in  1  data request; held high until d_done
- d_wr  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_done  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_W  load result; holds until next load completes
- mem_en  out  1  one-cycle command strobe to memory
- mem_wr  out  1  write qualifier, valid with mem_en
- mem_addr  out  ADDR_W  registered address, stable for the whole access
- mem_wdata  out  DATA_W  registered write data, stable for the whole access
- mem_rdata  in  DATA_W  memory read data, valid exactly MEM_LAT cycles after mem_en
- busy  out  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: the arbiter samples i_req and d_req.
  - Neither request high: stay in IDLE.
  - Exactly one high: grant that requester.
  - Both high: grant the requester opposite to last_grant.
  - On a grant: latch addr, wdata and wr into mem_* registers, record the owner (I or D), update last_grant, and go to ISSUE.
  - Fetches always latch mem_wr = 0.
- ISSUE: assert mem_en for exactly one cycle, load cnt = MEM_LAT, go to WAIT.
- WAIT: decrement cnt each cycle.
  - When cnt reaches 1, the current cycle is the mem_rdata-valid cycle.
  - For a read, capture mem_rdata into the owner's rdata register at the end of that cycle, then go to DONE.
  - For a write, take the same path without capturing data.
- DONE: pulse the owner's done for one cycle, then go to IDLE.
- last_grant resets to I, so the first contention grants D.
- Requests are sampled only in IDLE.
  - A request dropped before its grant is ignored.
  - A request dropped after its grant still completes, and its done still pulses.
- i_rdata is untouched by data accesses; d_rdata is untouched by fetches and by stores.
- The counter is 4 bits wide.

## Timing
- Reset values: state = IDLE, mem_en = 0, mem_wr = 0, mem_addr = 0, mem_wdata = 0, i_done = 0, d_done = 0, i_rdata = 0, d_rdata = 0, busy = 0, last_grant = I, cnt = 0.
- All outputs are registered; no combinational path from any input to any output.
- Request sampled in IDLE at cycle 0:
  - Cycle 1: mem_en = 1.
  - Cycle 1+MEM_LAT: mem_rdata captured.
  - Cycle 2+MEM_LAT: done = 1.
  - Cycle 3+MEM_LAT: back in IDLE and sampling.
- Latency from request sample to done is MEM_LAT+2 cycles.
- Minimum spacing between grants is MEM_LAT+3 cycles.
- busy is high from cycle 1 through cycle 2+MEM_LAT inclusive.
- rst asserted in any state:
  - The next edge returns every register to its reset value.
  - Any in-flight access is abandoned; no done pulses for it.
  - The memory response that arrives after reset is ignored.
- With rst held high, requests are never granted.
- The DONE cycle never issues a new mem_en; a request pending during DONE is granted on the following IDLE cycle.

## Test plan
- Fetch only, MEM_LAT = 4, i_addr = 0x0010, memory returns 0xB123: mem_en in cycle 1 with mem_addr = 0x0010 and mem_wr = 0. Required: i_done pulses in cycle 6, i_rdata = 0xB123, d_done never pulses.
- Store d_addr = 0x0040, d_wdata = 0x00AA, then load from 0x0040: store shows mem_wr = 1 and mem_wdata = 0x00AA, d_done pulses in cycle 6, d_rdata stays 0. Required: the load returns d_rdata = 0x00AA.
- i_req and d_req high together from reset and held, each re-raised immediately after its done: grants alternate D, I, D, I. Required: grants are spaced 7 cycles apart and neither done is missed.
- rst pulsed in the WAIT state of a load: no d_done for it, and all outputs are 0 the cycle after the reset edge. Required: a fresh fetch afterwards completes normally in 6 cycles.
- i_req dropped in the same cycle its grant is taken: mem_en still issues. Required: i_done still pulses in cycle 6; a second i_req pulsed low before IDLE sampling produces no access.
- Parameter sweep MEM_LAT = 1 and 15. Required: done arrives at cycles 3 and 17 respectively, with correct captured data.
